// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control unit: opcodes, ALU codes, bus source
// selects, the FSM state set and the packed control word.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0011;

  localparam logic [4:0] BUS_GPR  = 5'b00000;
  localparam logic [4:0] BUS_ZLOW = 5'b10011;
  localparam logic [4:0] BUS_PC   = 5'b10100;
  localparam logic [4:0] BUS_MDR  = 5'b10101;
  localparam logic [4:0] BUS_CSE  = 5'b11000;

  typedef enum logic [4:0] {
    S_RESET,
    S_T0, S_T1, S_T2, S_T3,
    S_MEM_E0, S_MEM_E1,
    S_LDI_E2,
    S_LD_E2, S_LD_E3, S_LD_E4, S_LD_E5,
    S_ST_E2, S_ST_E3, S_ST_E4,
    S_ALU_E0, S_ALU_E1, S_ADDI_E1, S_ALU_E2,
    S_BR_E0, S_BR_E1, S_BR_E2, S_BR_E3,
    S_NOP,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       incPC;
    logic       e_PC;
    logic       e_IR;
    logic       e_Y;
    logic       e_Z;
    logic       e_MAR;
    logic       e_MDR;
    logic       MDR_read;
    logic       ram_read;
    logic       ram_write;
    logic       e_CON_FF;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       e_Rin;
    logic       e_Rout;
    logic       BAout;
    logic       imm_sel;
    logic [3:0] ALU_op;
    logic [4:0] BusDataSelect;
    logic       run;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational map from an FSM state to its control word.
// Only the branch write-back state looks at the condition flag.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_con,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl     = '0;
    o_ctrl.run = (i_state != S_RESET) && (i_state != S_HALT);
    case (i_state)
      S_T0: begin
        o_ctrl.BusDataSelect = BUS_PC;
        o_ctrl.e_MAR         = 1'b1;
        o_ctrl.incPC         = 1'b1;
      end
      S_T1: o_ctrl.ram_read = 1'b1;
      S_T2: begin
        o_ctrl.MDR_read = 1'b1;
        o_ctrl.e_MDR    = 1'b1;
      end
      S_T3: begin
        o_ctrl.BusDataSelect = BUS_MDR;
        o_ctrl.e_IR          = 1'b1;
      end
      S_MEM_E0: begin
        o_ctrl.Grb    = 1'b1;
        o_ctrl.BAout  = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.e_Y    = 1'b1;
      end
      S_MEM_E1, S_ADDI_E1, S_BR_E2: begin
        o_ctrl.imm_sel       = 1'b1;
        o_ctrl.BusDataSelect = BUS_CSE;
        o_ctrl.ALU_op        = ALU_ADD;
        o_ctrl.e_Z           = 1'b1;
      end
      S_LDI_E2, S_ALU_E2: begin
        o_ctrl.BusDataSelect = BUS_ZLOW;
        o_ctrl.Gra           = 1'b1;
        o_ctrl.e_Rin         = 1'b1;
      end
      S_LD_E2, S_ST_E2: begin
        o_ctrl.BusDataSelect = BUS_ZLOW;
        o_ctrl.e_MAR         = 1'b1;
      end
      S_LD_E3: o_ctrl.ram_read = 1'b1;
      S_LD_E4: begin
        o_ctrl.MDR_read = 1'b1;
        o_ctrl.e_MDR    = 1'b1;
      end
      S_LD_E5: begin
        o_ctrl.BusDataSelect = BUS_MDR;
        o_ctrl.Gra           = 1'b1;
        o_ctrl.e_Rin         = 1'b1;
      end
      // Register value reaches the MDR through the bus, not from memory.
      S_ST_E3: begin
        o_ctrl.Gra    = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.e_MDR  = 1'b1;
      end
      S_ST_E4: o_ctrl.ram_write = 1'b1;
      S_ALU_E0: begin
        o_ctrl.Grb    = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.e_Y    = 1'b1;
      end
      S_ALU_E1: begin
        o_ctrl.Grc    = 1'b1;
        o_ctrl.e_Rout = 1'b1;
        o_ctrl.ALU_op = i_opcode[3:0];
        o_ctrl.e_Z    = 1'b1;
      end
      S_BR_E0: begin
        o_ctrl.Gra      = 1'b1;
        o_ctrl.e_Rout   = 1'b1;
        o_ctrl.e_CON_FF = 1'b1;
      end
      S_BR_E1: begin
        o_ctrl.BusDataSelect = BUS_PC;
        o_ctrl.e_Y           = 1'b1;
      end
      S_BR_E3: begin
        if (i_con) begin
          o_ctrl.BusDataSelect = BUS_ZLOW;
          o_ctrl.e_PC          = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the CPU: fetch T0-T3, per-opcode execute sequences,
// halt handling. Outputs are registered from the decoded next state.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_MAR,
  output logic        e_MDR,
  output logic        MDR_read,
  output logic        ram_read,
  output logic        ram_write,
  output logic        e_CON_FF,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        run
);

  state_t     r_state;
  state_t     w_nextState;
  state_t     w_boundary;
  ctrl_t      r_ctrl;
  ctrl_t      w_nextCtrl;
  logic [4:0] w_opcode;
  logic       w_unusedIrBits;

  assign w_opcode       = IR[31:27];
  assign w_unusedIrBits = |IR[26:0];

  // A halt request only takes effect where an instruction would begin.
  assign w_boundary = stop ? S_HALT : S_T0;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_RESET, S_LDI_E2, S_LD_E5, S_ST_E4,
      S_ALU_E2, S_BR_E3, S_NOP:  w_nextState = w_boundary;
      S_T0:      w_nextState = S_T1;
      S_T1:      w_nextState = S_T2;
      S_T2:      w_nextState = S_T3;
      S_T3: begin
        case (w_opcode)
          OP_LD, OP_LDI, OP_ST:                    w_nextState = S_MEM_E0;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:  w_nextState = S_ALU_E0;
          OP_BR:                                   w_nextState = S_BR_E0;
          OP_HALT:                                 w_nextState = S_HALT;
          default:                                 w_nextState = S_NOP;
        endcase
      end
      S_MEM_E0:  w_nextState = S_MEM_E1;
      S_MEM_E1: begin
        if (w_opcode == OP_LDI)     w_nextState = S_LDI_E2;
        else if (w_opcode == OP_LD) w_nextState = S_LD_E2;
        else                        w_nextState = S_ST_E2;
      end
      S_LD_E2:   w_nextState = S_LD_E3;
      S_LD_E3:   w_nextState = S_LD_E4;
      S_LD_E4:   w_nextState = S_LD_E5;
      S_ST_E2:   w_nextState = S_ST_E3;
      S_ST_E3:   w_nextState = S_ST_E4;
      S_ALU_E0:  w_nextState = (w_opcode == OP_ADDI) ? S_ADDI_E1 : S_ALU_E1;
      S_ALU_E1, S_ADDI_E1: w_nextState = S_ALU_E2;
      S_BR_E0:   w_nextState = S_BR_E1;
      S_BR_E1:   w_nextState = S_BR_E2;
      S_BR_E2:   w_nextState = S_BR_E3;
      S_HALT:    w_nextState = S_HALT;
      default:   w_nextState = S_RESET;
    endcase
  end

  ctrl_decode u_decode (
    .i_state  (w_nextState),
    .i_opcode (w_opcode),
    .i_con    (CON),
    .o_ctrl   (w_nextCtrl)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RESET;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= w_nextCtrl;
    end
  end

  assign incPC         = r_ctrl.incPC;
  assign e_PC          = r_ctrl.e_PC;
  assign e_IR          = r_ctrl.e_IR;
  assign e_Y           = r_ctrl.e_Y;
  assign e_Z           = r_ctrl.e_Z;
  assign e_MAR         = r_ctrl.e_MAR;
  assign e_MDR         = r_ctrl.e_MDR;
  assign MDR_read      = r_ctrl.MDR_read;
  assign ram_read      = r_ctrl.ram_read;
  assign ram_write     = r_ctrl.ram_write;
  assign e_CON_FF      = r_ctrl.e_CON_FF;
  assign Gra           = r_ctrl.Gra;
  assign Grb           = r_ctrl.Grb;
  assign Grc           = r_ctrl.Grc;
  assign e_Rin         = r_ctrl.e_Rin;
  assign e_Rout        = r_ctrl.e_Rout;
  assign BAout         = r_ctrl.BAout;
  assign imm_sel       = r_ctrl.imm_sel;
  assign ALU_op        = r_ctrl.ALU_op;
  assign BusDataSelect = r_ctrl.BusDataSelect;
  assign run           = r_ctrl.run;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clock in 1, rising-edge system clock; clear in 1, asynchronous active-low reset (0 = reset).
REQ-002 SHALL have inputs: IR in 32, instruction register contents (opcode IR[31:27]); CON in 1, registered branch-condition flag from datapath; stop in 1, halt request.
REQ-003 SHALL have outputs (all 1-bit unless noted): incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, ram_write, e_CON_FF, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, ALU_op (4), BusDataSelect (5), run.

Function
REQ-004 SHALL be a Moore FSM; every output is registered, decoded from the next state, and valid for exactly the state's one clock.
REQ-005 SHALL drive BusDataSelect with: 00000 GP register (via Gra/Grb/Grc), 10011 Zlow, 10100 PC, 10101 MDR, 11000 sign-extended C; any state not naming a source drives 00000.
REQ-006 SHALL fetch in T0 (BusDataSelect=PC, e_MAR, incPC), T1 (ram_read), T2 (MDR_read, e_MDR), T3 (BusDataSelect=MDR, e_IR); decode occurs on the clock after T3.
REQ-007 SHALL decode opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, br 10010, nop 11010, halt 11011; any other opcode behaves as nop.
REQ-008 SHALL drive ALU_op = 0011 (ADD) for address/immediate/branch computations and ALU_op = opcode[3:0] for R-type add/sub/and/or.
REQ-009 ldi: E0 Grb, BAout, e_Rout, e_Y; E1 imm_sel, ADD, e_Z; E2 BusDataSelect=Zlow, Gra, e_Rin; then T0 (7 cycles total).
REQ-010 ld: E0-E1 as ldi; E2 Zlow, e_MAR; E3 ram_read; E4 MDR_read, e_MDR; E5 BusDataSelect=MDR, Gra, e_Rin; then T0 (10 cycles).
REQ-011 st: E0-E1 as ldi; E2 Zlow, e_MAR; E3 Gra, e_Rout, e_MDR, MDR_read=0; E4 ram_write; then T0 (9 cycles).
REQ-012 R-type: E0 Grb, e_Rout, e_Y; E1 Grc, e_Rout, ALU_op, e_Z; E2 Zlow, Gra, e_Rin (7 cycles); addi identical except E1 uses imm_sel and ADD.
REQ-013 br: E0 Gra, e_Rout, e_CON_FF; E1 BusDataSelect=PC, e_Y; E2 imm_sel, ADD, e_Z; E3 Zlow, e_PC only if CON=1 at that edge, else no enables; then T0 (8 cycles).
REQ-014 nop: return to T0 directly after decode (5 cycles).
REQ-015 halt opcode, or stop=1 sampled on the clock that would enter T0, SHALL enter HALT: all enables 0, run=0, held until reset.
REQ-016 run SHALL be 1 in every state except RESET and HALT.
REQ-017 e_Rin and e_Rout SHALL never both be 1 in one state; ram_read and ram_write SHALL never both be 1.
REQ-018 stop asserted mid-instruction SHALL NOT abort it; the instruction completes and HALT is entered at the next T0 boundary.

Reset
REQ-019 clear=0 SHALL asynchronously force state RESET and every output to 0 (ALU_op=0000, BusDataSelect=00000, run=0), including mid-instruction.
REQ-020 After clear returns to 1, the first rising edge SHALL move RESET to T0; no memory strobe precedes T0.

Structure
REQ-021 Opcode constants, ALU_op codes, BusDataSelect codes and the state enumeration SHALL reside in shared package cpu_ctrl_pkg.
REQ-022 A single sub-module, ctrl_decode (combinational state-to-control-word mapping), is natural; next-state logic and output registers stay in control_unit.

Verification
REQ-023 Reset, release, IR=0x08800078 (ldi R1,0x78): T0..T3 strobes in order, then Grb/BAout/e_Y, imm_sel/ADD/e_Z, Zlow/Gra/e_Rin, back to T0 on cycle 8.
REQ-024 IR=ld opcode: e_MAR asserted at T0 and E2, ram_read at T1 and E3, Gra/e_Rin with BusDataSelect=10101 on cycle 10.
REQ-025 IR=br opcode, CON=1: e_PC with BusDataSelect=10011 in E3; repeat with CON=0: e_PC stays 0 for the whole instruction.
REQ-026 IR=sub opcode: ALU_op=0100 exactly in E1 with Grc and e_Z; IR=0xFFFFFFFF (undefined): nop timing, no register or memory enable.
REQ-027 stop=1 raised during st E1: ram_write still occurs in E4, then HALT, run=0; clear=0 pulsed during ld E3: all outputs 0 immediately, restart at T0.
